instruction_fetch: RTL

Fetch stage of the RV32IM pipeline and producer side of the IF→ID interface: owns the program counter, issues word reads to instruction memory over a request/valid handshake, and presents `IF_PC`, `IF_PC_PLUS4`, `IF_INSTRUCTION` and `IF_VALID` to the decode stage. Honours decode-side stalls through a one-entry skid buffer. Honours EX-side branch/jump redirects, squashing wrong-path fetches including any in-flight memory response.

---
 rtl/instruction_fetch_pkg.sv | 6 +
 rtl/instruction_fetch.sv | 75 +++++++
 2 files changed

// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: fetch state encoding and constants shared with ID/EX flush logic
package instruction_fetch_pkg;
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} if_state_t;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner, single-outstanding imem reader and IF->ID skid stage
module instruction_fetch
  import instruction_fetch_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_VALID,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PC_PLUS4,
  output logic [31:0] IF_INSTRUCTION,
  output logic        IF_VALID
);
  if_state_t   state, state_n;
  logic [31:0] pc, skid_instr, skid_pc;
  always_ff @(posedge CLK)
    state <= RST ? FETCH : state_n;
  always_comb begin
    state_n = state;
    if (REDIRECT)
      state_n = (state != HOLD && !IMEM_VALID) ? DRAIN : FETCH;
    else
      case (state)
        FETCH:   state_n = (IMEM_VALID && STALL) ? HOLD : FETCH;
        HOLD:    state_n = STALL ? HOLD : FETCH;
        DRAIN:   state_n = IMEM_VALID ? FETCH : DRAIN;
        default: state_n = FETCH;
      endcase
  end
  always_comb begin
    IMEM_REQ  = (state == FETCH) && !RST;
    IMEM_ADDR = pc;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc             <= RESET_PC;
      skid_instr     <= '0;
      skid_pc        <= '0;
      IF_PC          <= '0;
      IF_PC_PLUS4    <= '0;
      IF_INSTRUCTION <= NOP_INSTR;
      IF_VALID       <= 1'b0;
    end else if (REDIRECT) begin
      pc             <= REDIRECT_PC & ~32'h3;
      skid_instr     <= '0;
      skid_pc        <= '0;
      IF_INSTRUCTION <= NOP_INSTR;
      IF_VALID       <= 1'b0;
    end else if (state == FETCH && IMEM_VALID) begin
      pc <= pc + 32'd4;
      if (STALL) begin
        skid_instr <= IMEM_RDATA;
        skid_pc    <= pc;
      end else begin
        IF_PC          <= pc;
        IF_PC_PLUS4    <= pc + 32'd4;
        IF_INSTRUCTION <= IMEM_RDATA;
        IF_VALID       <= 1'b1;
      end
    end else if (state == FETCH && !STALL) begin
      IF_INSTRUCTION <= NOP_INSTR;
      IF_VALID       <= 1'b0;
    end else if (state == HOLD && !STALL) begin
      IF_PC          <= skid_pc;
      IF_PC_PLUS4    <= skid_pc + 32'd4;
      IF_INSTRUCTION <= skid_instr;
      IF_VALID       <= 1'b1;
    end
  end
endmodule
